// File: rtl/img_window_sched.sv
// Bouncing image-window scheduler for the DVI raster: per-pixel requests,
// frame restarts and per-frame count check. Optional border: IMG_WIN_BORDER_EN.
module img_window_sched #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int IMG_W    = 225,
    parameter int IMG_H    = 225,
    parameter int START_X  = 50,
    parameter int START_Y  = 50,
    parameter int STEP_X   = 1,
    parameter int STEP_Y   = 1
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic [CW-1:0] i_hcnt,
    input  logic [CW-1:0] i_vcnt,
    input  logic          i_vsync,
    input  logic          i_enable,
    input  logic          i_pause,
    output logic          o_req,
    output logic          o_frame_start,
    output logic [CW-1:0] o_pos_x,
    output logic [CW-1:0] o_pos_y,
    output logic          o_err
`ifdef IMG_WIN_BORDER_EN
    ,
    output logic          o_border
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACT  = 2'd2;
    localparam logic [1:0] S_UPD  = 2'd3;

    localparam logic [CW:0] X_MAX = (CW+1)'(H_ACTIVE - IMG_W);
    localparam logic [CW:0] Y_MAX = (CW+1)'(V_ACTIVE - IMG_H);
    localparam logic [CW:0] SX    = (CW+1)'(STEP_X);
    localparam logic [CW:0] SY    = (CW+1)'(STEP_Y);
    localparam logic [CW:0] IW    = (CW+1)'(IMG_W);
    localparam logic [CW:0] IH    = (CW+1)'(IMG_H);

    localparam logic [2*CW-1:0] CNT_EXP = (2*CW)'(IMG_W * IMG_H);

    logic [1:0]      r_state;
    logic [1:0]      w_nstate;
    logic            r_vs_q;
    logic            w_vs_fall;
    logic            r_req;
    logic            r_fs;
    logic            r_err;
    logic [CW-1:0]   r_pos_x;
    logic [CW-1:0]   r_pos_y;
    logic            r_dx;
    logic            r_dy;
    logic [2*CW-1:0] r_cnt;

    logic [CW:0]     w_hc;
    logic [CW:0]     w_vc;
    logic [CW:0]     w_px;
    logic [CW:0]     w_py;
    logic [CW:0]     w_x_end;
    logic [CW:0]     w_y_end;
    logic            w_win;
    logic            w_upd;
    logic [CW:0]     w_bx;
    logic [CW:0]     w_by;

    // Returns {new_dir, new_pos}; dir=1 means moving toward the far edge.
    function automatic logic [CW:0] bounce(
        input logic [CW-1:0] pos,
        input logic          dir,
        input logic [CW:0]   step,
        input logic [CW:0]   lim
    );
        logic [CW:0] sum;
        logic [CW:0] res;
        sum = {1'b0, pos} + step;
        res = {dir, pos};
        if (dir) begin
            if (sum >= lim) begin
                res = {1'b0, lim[CW-1:0]};
            end else begin
                res = {1'b1, sum[CW-1:0]};
            end
        end else begin
            if ({1'b0, pos} <= step) begin
                res = {1'b1, {CW{1'b0}}};
            end else begin
                res = {1'b0, pos - step[CW-1:0]};
            end
        end
        return res;
    endfunction

    assign w_vs_fall = r_vs_q & ~i_vsync;

    assign w_hc    = {1'b0, i_hcnt};
    assign w_vc    = {1'b0, i_vcnt};
    assign w_px    = {1'b0, r_pos_x};
    assign w_py    = {1'b0, r_pos_y};
    assign w_x_end = w_px + IW;
    assign w_y_end = w_py + IH;

    assign w_win = (w_hc >= w_px) && (w_hc < w_x_end) &&
                   (w_vc >= w_py) && (w_vc < w_y_end);

    assign w_upd = (r_state == S_UPD) && i_enable;

    assign w_bx = bounce(r_pos_x, r_dx, SX, X_MAX);
    assign w_by = bounce(r_pos_y, r_dy, SY, Y_MAX);

    always_comb begin
        w_nstate = r_state;
        unique case (r_state)
            S_IDLE: w_nstate = S_WAIT;
            S_WAIT: if (w_vs_fall) w_nstate = S_ACT;
            S_ACT:  if (w_vs_fall) w_nstate = S_UPD;
            S_UPD:  w_nstate = S_ACT;
            default: w_nstate = S_IDLE;
        endcase
        if (!i_enable) w_nstate = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_vs_q  <= 1'b0;
            r_req   <= 1'b0;
            r_fs    <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_vs_q  <= i_vsync;
            r_req   <= w_win && (r_state == S_ACT) && i_enable;
            r_fs    <= i_enable && w_vs_fall &&
                       ((r_state == S_WAIT) || (r_state == S_ACT));
        end
    end

    // Counter restarts at every frame boundary and whenever idle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state == S_IDLE) || (r_state == S_UPD) ||
                     ((r_state == S_WAIT) && w_vs_fall)) begin
            r_cnt <= '0;
        end else if (r_req && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_upd && (r_cnt != CNT_EXP)) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_pos_x <= CW'(START_X);
            r_pos_y <= CW'(START_Y);
            r_dx    <= 1'b1;
            r_dy    <= 1'b1;
        end else if (w_upd && !i_pause) begin
            r_pos_x <= w_bx[CW-1:0];
            r_dx    <= w_bx[CW];
            r_pos_y <= w_by[CW-1:0];
            r_dy    <= w_by[CW];
        end
    end

    assign o_req         = r_req;
    assign o_frame_start = r_fs;
    assign o_pos_x       = r_pos_x;
    assign o_pos_y       = r_pos_y;
    assign o_err         = r_err;

`ifdef IMG_WIN_BORDER_EN
    logic        r_border;
    logic [CW:0] w_hc_p1;
    logic [CW:0] w_vc_p1;
    logic        w_ring;
    logic        w_on_scr;

    assign w_hc_p1 = w_hc + 1'b1;
    assign w_vc_p1 = w_vc + 1'b1;

    // One-pixel ring: the window grown by one on every side, minus the window.
    assign w_ring = (w_hc_p1 >= w_px) && (w_hc <= w_x_end) &&
                    (w_vc_p1 >= w_py) && (w_vc <= w_y_end) && !w_win;

    assign w_on_scr = (w_hc < (CW+1)'(H_ACTIVE)) &&
                      (w_vc < (CW+1)'(V_ACTIVE));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_border <= 1'b0;
        end else begin
            r_border <= w_ring && w_on_scr &&
                        (r_state == S_ACT) && i_enable;
        end
    end

    assign o_border = r_border;
`endif

endmodule

// File: tb/tb_img_window_sched.sv
// Scoreboarded bench for img_window_sched on a reduced 16x12 raster
// (20x15 total) with a 5x4 window so bounces happen within a few frames.
module tb_img_window_sched;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] i_hcnt = '0;
    logic [CW-1:0] i_vcnt = '0;
    logic          i_vsync = 1'b1;
    logic          i_enable = 1'b0;
    logic          i_pause = 1'b0;
    logic          o_req;
    logic          o_frame_start;
    logic [CW-1:0] o_pos_x;
    logic [CW-1:0] o_pos_y;
    logic          o_err;
`ifdef IMG_WIN_BORDER_EN
    logic          o_border;
`endif

    img_window_sched #(
        .CW(CW), .H_ACTIVE(16), .V_ACTIVE(12),
        .IMG_W(5), .IMG_H(4),
        .START_X(3), .START_Y(2),
        .STEP_X(1), .STEP_Y(1)
    ) dut (
        .clk_i(clk),
        .rst_n(rst_n),
        .i_hcnt(i_hcnt),
        .i_vcnt(i_vcnt),
        .i_vsync(i_vsync),
        .i_enable(i_enable),
        .i_pause(i_pause),
        .o_req(o_req),
        .o_frame_start(o_frame_start),
        .o_pos_x(o_pos_x),
        .o_pos_y(o_pos_y),
        .o_err(o_err)
`ifdef IMG_WIN_BORDER_EN
        ,
        .o_border(o_border)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int err;
        int reqs;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   h = 0;
    int   v = 0;
    bit   inj_en = 1'b0;
    int   mon_reqs = 0;
    bit   mon_pend = 1'b0;

    int tx [21] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 10, 9,
                    8, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int ty [21] = '{2, 3, 4, 5, 6, 7, 8, 7, 6, 5, 4,
                    3, 2, 1, 0, 1, 2, 3, 4, 5, 6};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int x, input int y, input int e,
                        input int r);
        exp_t t;
        t.x = x;
        t.y = y;
        t.err = e;
        t.reqs = r;
        q.push_back(t);
    endtask

    task automatic tick();
        @(negedge clk);
        i_hcnt  = CW'(h);
        i_vcnt  = CW'(v);
        i_vsync = !((v == 13) || (inj_en && v == 9 && h < 2));
        h++;
        if (h == 20) begin
            h = 0;
            v++;
            if (v == 15) v = 0;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int th, input int tv);
        int n;
        n = 0;
        while (!(h == th && v == tv) && n < 400) begin
            tick();
            n++;
        end
        chk("run_to bound", int'(h == th && v == tv), 1);
    endtask

`ifdef IMG_WIN_BORDER_EN
    task automatic probe(input int th, input int tv, input int eb);
        run_to(th, tv);
        tick();
        @(posedge clk);
        #1;
        chk($sformatf("border(%0d,%0d)", th, tv), int'(o_border), eb);
    endtask
`endif

    // Monitor: one scoreboard entry per frame_start, checked a cycle later.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_pend = 1'b0;
            mon_reqs = 0;
        end else begin
            if (o_req) mon_reqs++;
            if (mon_pend) begin
                mon_pend = 1'b0;
                if (q.size() == 0) begin
                    chk("unexpected frame_start", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("frame pos_x", int'(o_pos_x), e.x);
                    chk("frame pos_y", int'(o_pos_y), e.y);
                    chk("frame err", int'(o_err), e.err);
                    chk("frame reqs", mon_reqs, e.reqs);
                end
                mon_reqs = 0;
            end
            if (o_frame_start) mon_pend = 1'b1;
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst req", int'(o_req), 0);
        chk("rst fs", int'(o_frame_start), 0);
        chk("rst err", int'(o_err), 0);
        chk("rst pos_x", int'(o_pos_x), 3);
        chk("rst pos_y", int'(o_pos_y), 2);
        rst_n = 1'b1;
        i_enable = 1'b1;

        for (int i = 0; i < 21; i++)
            push(tx[i], ty[i], 0, (i == 0) ? 0 : 20);
        run(300);
        run(1);
`ifdef IMG_WIN_BORDER_EN
        probe(2, 3, 1);
        probe(3, 3, 0);
        probe(8, 3, 1);
        probe(9, 3, 0);
        probe(8, 6, 1);
`endif
        run_to(0, 0);
        run(19 * 300);

        i_pause = 1'b1;
        for (int i = 0; i < 4; i++) push(1, 6, 0, 20);
        run(4 * 300);
        i_pause = 1'b0;
        push(2, 7, 0, 20);
        run(300);

        run_to(4, 8);
        tick();
        tick();
        chk("req before disable", int'(o_req), 1);
        i_enable = 1'b0;
        tick();
        chk("req after disable", int'(o_req), 0);
        run_to(0, 0);
        i_enable = 1'b1;
        push(2, 7, 0, 8);
        push(3, 8, 0, 20);
        run(2 * 300);

        inj_en = 1'b1;
        push(4, 7, 1, 5);
        push(5, 6, 1, 10);
        run(300);
        inj_en = 1'b0;
        push(6, 5, 1, 20);
        run(300);

        run(150);
        chk("queue drained", q.size(), 0);
        chk("err sticky", int'(o_err), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst err", int'(o_err), 0);
        chk("midrst pos_x", int'(o_pos_x), 3);
        chk("midrst pos_y", int'(o_pos_y), 2);
        chk("midrst req", int'(o_req), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
